// File: rtl/answer_checker.sv
// answer_checker: walks the decrypted-message RAM (addresses 0..MESSAGE_LENGTH-1)
// and decides whether every byte is a lowercase letter or a space. The result
// (pass/fail, first bad index and byte) lets the key-search controller accept
// or reject the current key. The walk stops at the first illegal byte.
module answer_checker #(
  parameter int RAM_WIDTH          = 8,
  parameter int RAM_LENGTH         = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter logic [RAM_WIDTH-1:0] LOW_CHAR   = 8'h61,
  parameter logic [RAM_WIDTH-1:0] HIGH_CHAR  = 8'h7A,
  parameter logic [RAM_WIDTH-1:0] SPACE_CHAR = 8'h20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [RAM_WIDTH-1:0]          aOut,
  output logic [RAM_LENGTH-1:0]         aAddr,
  output logic                          busy,
  output logic                          finished,
  output logic                          valid,
  output logic [MESSAGE_LOG_LENGTH-1:0] failIndex,
  output logic [RAM_WIDTH-1:0]          failChar
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_IDX = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
  localparam logic [MESSAGE_LOG_LENGTH-1:0] ONE_IDX  = MESSAGE_LOG_LENGTH'(1);

  state_t                          state_q, state_d;
  logic [MESSAGE_LOG_LENGTH-1:0]   k_q, k_d;
  logic                            start_q;
  logic                            start_sig;
  logic [RAM_LENGTH-1:0]           aAddr_q, aAddr_d;
  logic                            busy_q, busy_d;
  logic                            finished_q, finished_d;
  logic                            valid_q, valid_d;
  logic [MESSAGE_LOG_LENGTH-1:0]   failIndex_q, failIndex_d;
  logic [RAM_WIDTH-1:0]            failChar_q, failChar_d;

  // A byte is acceptable if it is a lowercase letter or the space character.
  function automatic logic is_legal(input logic [RAM_WIDTH-1:0] b);
    return ((b >= LOW_CHAR) && (b <= HIGH_CHAR)) || (b == SPACE_CHAR);
  endfunction

  // A held start level counts as one request: only the rising edge matters.
  assign start_sig = start & ~start_q;

  // Next-state, index and result logic; address/busy derive from the next state
  // so the RAM sees the address for the whole ISSUE+CHECK pair.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    finished_d  = finished_q;
    valid_d     = valid_q;
    failIndex_d = failIndex_q;
    failChar_d  = failChar_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_sig) begin
          state_d     = ISSUE;
          k_d         = '0;
          finished_d  = 1'b0;
          valid_d     = 1'b0;
          failIndex_d = '0;
          failChar_d  = '0;
        end else begin
          finished_d  = (state_q == DONE);
        end
      end
      ISSUE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (!is_legal(aOut)) begin
          state_d     = DONE;
          valid_d     = 1'b0;
          failIndex_d = k_q;
          failChar_d  = aOut;
        end else if (k_q == LAST_IDX) begin
          state_d     = DONE;
          valid_d     = 1'b1;
        end else begin
          state_d     = ISSUE;
          k_d         = k_q + ONE_IDX;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
    busy_d  = (state_d == ISSUE) || (state_d == CHECK);
    aAddr_d = busy_d ? RAM_LENGTH'(k_d) : '0;
  end

  // State, index and registered outputs; reset aborts any check in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      start_q     <= 1'b0;
      aAddr_q     <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      valid_q     <= 1'b0;
      failIndex_q <= '0;
      failChar_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      start_q     <= start;
      aAddr_q     <= aAddr_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      valid_q     <= valid_d;
      failIndex_q <= failIndex_d;
      failChar_q  <= failChar_d;
    end
  end

  assign aAddr     = aAddr_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign valid     = valid_q;
  assign failIndex = failIndex_q;
  assign failChar  = failChar_q;

endmodule

// File: tb/tb_answer_checker.sv
// Bench for answer_checker: a RAM model with 1-cycle read latency, a reference
// model that pushes expected read addresses and results into queues at start,
// a negedge monitor that pops expected addresses, and one task per scenario.
module tb_answer_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] aOut;
  logic [7:0] aAddr;
  logic       busy, finished, valid;
  logic [4:0] failIndex;
  logic [7:0] failChar;

  logic [7:0] mem [0:255];

  typedef struct {
    logic       v;
    logic [4:0] fi;
    logic [7:0] fc;
    int         lat;
  } exp_t;

  exp_t       res_q[$];
  logic [7:0] addr_q[$];
  int         pass_cnt = 0;
  int         chk_cnt  = 0;

  answer_checker dut (
    .clk(clk), .reset(reset), .start(start), .aOut(aOut), .aAddr(aAddr),
    .busy(busy), .finished(finished), .valid(valid),
    .failIndex(failIndex), .failChar(failChar)
  );

  always #5 clk = ~clk;

  // Synchronous-read message RAM
  always @(posedge clk) aOut <= mem[aAddr];

  // Address scoreboard: every busy cycle must show the next expected address
  always @(negedge clk) begin
    if (busy) begin
      chk_cnt++;
      if (addr_q.size() == 0) begin
        $display("FAIL read_addr: unexpected read at address %0d, none expected", aAddr);
      end else begin
        logic [7:0] ea;
        ea = addr_q.pop_front();
        if (aAddr !== ea) $display("FAIL read_addr: got address %0d, expected %0d", aAddr, ea);
        else pass_cnt++;
      end
    end
  end

  function automatic logic legal(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic model_push();
    exp_t e;
    int   f;
    int   last;
    f = -1;
    for (int i = 0; i < 32; i++) if (f < 0 && !legal(mem[i])) f = i;
    if (f < 0) begin
      e.v = 1'b1; e.fi = 5'd0; e.fc = 8'd0; e.lat = 65; last = 31;
    end else begin
      e.v = 1'b0; e.fi = 5'(f); e.fc = mem[f]; e.lat = 2 * f + 3; last = f;
    end
    for (int a = 0; a <= last; a++) begin
      addr_q.push_back(8'(a));
      addr_q.push_back(8'(a));
    end
    res_q.push_back(e);
  endtask

  task automatic fill_attack();
    string s;
    s = "attack at dawn";
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = (i < s.len()) ? s[i] : 8'h20;
  endtask

  // Drive start (held for 'hold' edges, optional stray pulse after edge 'stray'),
  // then count edges after the registering edge until finished rises.
  task automatic launch(input int hold, input int stray, output int n,
                        output logic fin0, output logic val0);
    n = -1;
    @(negedge clk);
    model_push();
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= 200; i++) begin
      if (i > 0) @(posedge clk);
      #1;
      if (i == 0) begin fin0 = finished; val0 = valid; end
      if (i >= hold - 1) start = 1'b0;
      if (stray > 0 && i == stray) start = 1'b1;
      if (stray > 0 && i == stray + 1) start = 1'b0;
      if (i > 0 && finished) begin n = i; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({busy, finished, valid, failIndex, failChar, aAddr} !== 24'd0)
      $display("FAIL reset_state: got busy=%b fin=%b valid=%b idx=%0d chr=%h addr=%0d, expected all 0",
               busy, finished, valid, failIndex, failChar, aAddr);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_attack();
    int n; logic f0, v0; exp_t e;
    fill_attack();
    launch(1, 0, n, f0, v0);
    e = res_q.pop_front();
    chk_cnt++;
    if (n !== e.lat) $display("FAIL attack_latency: got %0d edges, expected %0d", n, e.lat);
    else pass_cnt++;
    chk_cnt++;
    if ({valid, failIndex, failChar} !== {e.v, e.fi, e.fc})
      $display("FAIL attack_result: got valid=%b idx=%0d chr=%h, expected valid=%b idx=%0d chr=%h",
               valid, failIndex, failChar, e.v, e.fi, e.fc);
    else pass_cnt++;
  endtask

  task automatic test_fail_edges();
    int n; logic f0, v0; exp_t e;
    for (int t = 0; t < 2; t++) begin
      fill_attack();
      if (t == 0) mem[0] = 8'h41; else mem[31] = 8'h7B;
      launch(1, 0, n, f0, v0);
      e = res_q.pop_front();
      chk_cnt++;
      if (n !== e.lat) $display("FAIL fail_latency_%0d: got %0d edges, expected %0d", t, n, e.lat);
      else pass_cnt++;
      chk_cnt++;
      if ({finished, valid, failIndex, failChar} !== {1'b1, e.v, e.fi, e.fc})
        $display("FAIL fail_result_%0d: got fin=%b valid=%b idx=%0d chr=%h, expected fin=1 valid=%b idx=%0d chr=%h",
                 t, finished, valid, failIndex, failChar, e.v, e.fi, e.fc);
      else pass_cnt++;
    end
  endtask

  task automatic test_boundary();
    int n; logic f0, v0; exp_t e;
    logic [7:0] good [3];
    logic [7:0] bad [4];
    good = '{8'h20, 8'h61, 8'h7A};
    bad  = '{8'h00, 8'h60, 8'h1F, 8'h80};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = good[i % 3];
      if (t > 0) mem[5] = bad[t];
      launch(1, 0, n, f0, v0);
      e = res_q.pop_front();
      chk_cnt++;
      if (n !== e.lat || {valid, failIndex, failChar} !== {e.v, e.fi, e.fc})
        $display("FAIL boundary_%0d: got lat=%0d valid=%b idx=%0d chr=%h, expected lat=%0d valid=%b idx=%0d chr=%h",
                 t, n, valid, failIndex, failChar, e.lat, e.v, e.fi, e.fc);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_held();
    int n; logic f0, v0; exp_t e;
    fill_attack();
    launch(10, 0, n, f0, v0);
    e = res_q.pop_front();
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++;
    if (n !== e.lat || busy !== 1'b0 || finished !== 1'b1 || valid !== e.v)
      $display("FAIL start_held: got lat=%0d busy=%b fin=%b valid=%b, expected lat=%0d busy=0 fin=1 valid=%b",
               n, busy, finished, valid, e.lat, e.v);
    else pass_cnt++;
  endtask

  task automatic test_stray_start();
    int n; logic f0, v0; exp_t e;
    fill_attack();
    mem[20] = 8'h2E;
    launch(1, 21, n, f0, v0);
    e = res_q.pop_front();
    chk_cnt++;
    if (n !== e.lat || {valid, failIndex, failChar} !== {e.v, e.fi, e.fc})
      $display("FAIL stray_start: got lat=%0d valid=%b idx=%0d chr=%h, expected lat=%0d valid=%b idx=%0d chr=%h",
               n, valid, failIndex, failChar, e.lat, e.v, e.fi, e.fc);
    else pass_cnt++;
  endtask

  task automatic test_done_restart();
    int n; logic f0, v0; exp_t e;
    fill_attack();
    launch(1, 0, n, f0, v0);
    void'(res_q.pop_front());
    launch(1, 0, n, f0, v0);
    e = res_q.pop_front();
    chk_cnt++;
    if (f0 !== 1'b0 || v0 !== 1'b0)
      $display("FAIL restart_clear: got fin=%b valid=%b after restart edge, expected 0 0", f0, v0);
    else pass_cnt++;
    chk_cnt++;
    if (n !== e.lat || valid !== e.v)
      $display("FAIL restart_run: got lat=%0d valid=%b, expected lat=%0d valid=%b", n, valid, e.lat, e.v);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n; logic f0, v0; logic got; exp_t e;
    fill_attack();
    @(negedge clk);
    model_push();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && aAddr == 8'd12) begin got = 1'b1; break; end
    end
    #2 reset = 1'b1;
    #1;
    addr_q.delete();
    res_q.delete();
    chk_cnt++;
    if (!got || {busy, finished, valid, failIndex, failChar, aAddr} !== 24'd0)
      $display("FAIL reset_mid: reached=%b got busy=%b fin=%b valid=%b idx=%0d chr=%h addr=%0d, expected all 0",
               got, busy, finished, valid, failIndex, failChar, aAddr);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    launch(1, 0, n, f0, v0);
    e = res_q.pop_front();
    chk_cnt++;
    if (n !== e.lat || {valid, failIndex, failChar} !== {e.v, e.fi, e.fc})
      $display("FAIL reset_rerun: got lat=%0d valid=%b idx=%0d chr=%h, expected lat=%0d valid=%b idx=%0d chr=%h",
               n, valid, failIndex, failChar, e.lat, e.v, e.fi, e.fc);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_attack();
    test_fail_edges();
    test_boundary();
    test_start_held();
    test_stray_start();
    test_done_restart();
    test_reset_mid();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (addr_q.size() != 0) $display("FAIL reads_done: %0d expected reads never seen, expected 0", addr_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
